// File: rtl/priority_bit_serializer.sv
// priority_bit_serializer
//   Accepts a WIDTH-bit word over a valid/ready handshake and emits each set
//   bit as a separate one-hot beat with its binary index, one beat per cycle.
//   The beat order is chosen per word: LSB-first or MSB-first. An all-zero
//   word produces a single beat that is flagged empty.
//
// Ports
//   clk_i         clock, rising edge
//   srst_i        synchronous active-high reset
//   data_i        word to serialise
//   dir_i         beat order for the word (0 = LSB-first, 1 = MSB-first)
//   data_val_i    data_i / dir_i valid
//   data_ready_o  word can be accepted this cycle
//   onehot_o      current set bit, one-hot
//   index_o       binary position of onehot_o
//   last_o        final beat of the word
//   empty_o       accepted word was all-zero
//   data_val_o    output beat valid
//   data_ready_i  downstream accepts the beat
//
// State | meaning
//   IDLE  | no word held; ready for a new word
//   BUSY  | presenting beats from the residual register r_rem
module priority_bit_serializer #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] onehot_o,
  output logic [IDX_W-1:0] index_o,
  output logic             last_o,
  output logic             empty_o,
  output logic             data_val_o,
  input  logic             data_ready_i
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic             r_dir;
  logic             r_empty;

  logic [WIDTH-1:0] w_lsb;
  logic [WIDTH-1:0] w_msb;
  logic [WIDTH-1:0] w_onehot;
  logic [IDX_W-1:0] w_index;
  logic             w_single;
  logic             w_busy;
  logic             w_last;
  logic             w_beat;
  logic             w_accept;

  // Lowest set bit via two's complement; highest set bit by a scan where
  // the last hit wins.
  always_comb begin
    w_lsb = r_rem & (~r_rem + WIDTH'(1));
    w_msb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_rem[i]) begin
        w_msb    = '0;
        w_msb[i] = 1'b1;
      end
    end
  end

  assign w_onehot = r_dir ? w_msb : w_lsb;

  always_comb begin
    w_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_onehot[i]) w_index = IDX_W'(i);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest bit leaves zero.
  assign w_single = (r_rem != '0) && ((r_rem & (r_rem - WIDTH'(1))) == '0);

  assign w_busy   = (r_state == BUSY);
  assign w_last   = w_busy && (w_single || r_empty);
  assign w_beat   = w_busy && data_ready_i;

  // Ready in BUSY only when the final beat leaves this cycle, so the next
  // word can follow without a bubble. Held low while reset is asserted.
  assign data_ready_o = !srst_i && (!w_busy || (data_ready_i && w_last));
  assign w_accept     = data_val_i && data_ready_o;

  assign data_val_o = w_busy;
  assign onehot_o   = w_busy ? w_onehot : '0;
  assign index_o    = w_busy ? w_index : '0;
  assign last_o     = w_last;
  assign empty_o    = w_busy && r_empty;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_empty <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rem   <= data_i;
            r_dir   <= dir_i;
            r_empty <= (data_i == '0);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_beat) begin
            if (!w_last) begin
              r_rem <= r_rem & ~w_onehot;
            end else if (w_accept) begin
              r_rem   <= data_i;
              r_dir   <= dir_i;
              r_empty <= (data_i == '0);
            end else begin
              r_rem   <= '0;
              r_empty <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_bit_serializer.sv
module tb_priority_bit_serializer;

  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  logic             clk_i = 1'b0;
  logic             srst_i;
  logic [WIDTH-1:0] data_i;
  logic             dir_i;
  logic             data_val_i;
  logic             data_ready_o;
  logic [WIDTH-1:0] onehot_o;
  logic [IDX_W-1:0] index_o;
  logic             last_o;
  logic             empty_o;
  logic             data_val_o;
  logic             data_ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  priority_bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .data_i       (data_i),
    .dir_i        (dir_i),
    .data_val_i   (data_val_i),
    .data_ready_o (data_ready_o),
    .onehot_o     (onehot_o),
    .index_o      (index_o),
    .last_o       (last_o),
    .empty_o      (empty_o),
    .data_val_o   (data_val_o),
    .data_ready_i (data_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance one cycle; inputs are driven and outputs sampled 2 time units
  // after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic test_reset();
    srst_i = 1'b1; data_val_i = 1'b0; data_i = '0; dir_i = 1'b0; data_ready_i = 1'b1;
    tick();
    tick();
    #1;
    n_checks++;
    if (data_ready_o !== 1'b0) begin $display("FAIL reset_ready got=%b exp=0", data_ready_o); n_fail++; end
    n_checks++;
    if ({data_val_o, last_o, empty_o} !== 3'b000) begin
      $display("FAIL reset_flags got val/last/empty=%b%b%b exp=000", data_val_o, last_o, empty_o); n_fail++;
    end
    n_checks++;
    if (onehot_o !== 16'h0000 || index_o !== 4'd0) begin
      $display("FAIL reset_data got onehot=%h idx=%0d exp=0000/0", onehot_o, index_o); n_fail++;
    end
    srst_i = 1'b0;
    #1;
    n_checks++;
    if (data_ready_o !== 1'b1) begin $display("FAIL reset_release_ready got=%b exp=1", data_ready_o); n_fail++; end
  endtask

  // Present a word while IDLE and let it be accepted; returns positioned on
  // the first beat with data_val_i deasserted.
  task automatic send_word(input logic [WIDTH-1:0] w, input logic d);
    data_i = w; dir_i = d; data_val_i = 1'b1;
    tick();
    data_val_i = 1'b0;
    #1;
  endtask

  task automatic check_beat(input string name, input logic [WIDTH-1:0] eo,
                            input logic [IDX_W-1:0] ei, input logic el,
                            input logic ee, input logic er);
    n_checks++;
    if (data_val_o !== 1'b1 || onehot_o !== eo || index_o !== ei || last_o !== el
        || empty_o !== ee || data_ready_o !== er) begin
      $display("FAIL %s got val=%b onehot=%h idx=%0d last=%b empty=%b rdy=%b exp val=1 onehot=%h idx=%0d last=%b empty=%b rdy=%b",
               name, data_val_o, onehot_o, index_o, last_o, empty_o, data_ready_o, eo, ei, el, ee, er);
      n_fail++;
    end
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (data_val_o !== 1'b0 || onehot_o !== '0 || index_o !== '0 || last_o !== 1'b0
        || empty_o !== 1'b0 || data_ready_o !== 1'b1) begin
      $display("FAIL %s got val=%b onehot=%h idx=%0d last=%b empty=%b rdy=%b exp idle 0/0000/0/0/0 rdy=1",
               name, data_val_o, onehot_o, index_o, last_o, empty_o, data_ready_o);
      n_fail++;
    end
  endtask

  task automatic test_lsb_first();
    data_ready_i = 1'b1;
    send_word(16'h0012, 1'b0);
    check_beat("lsb_beat1", 16'h0002, 4'd1, 1'b0, 1'b0, 1'b0);
    tick(); #1;
    check_beat("lsb_beat2", 16'h0010, 4'd4, 1'b1, 1'b0, 1'b1);
    tick(); #1;
    check_idle("lsb_idle");
  endtask

  task automatic test_msb_first();
    data_ready_i = 1'b1;
    send_word(16'h0012, 1'b1);
    check_beat("msb_beat1", 16'h0010, 4'd4, 1'b0, 1'b0, 1'b0);
    tick(); #1;
    check_beat("msb_beat2", 16'h0002, 4'd1, 1'b1, 1'b0, 1'b1);
    tick(); #1;
    check_idle("msb_idle");
  endtask

  task automatic test_empty();
    data_ready_i = 1'b1;
    send_word(16'h0000, 1'b0);
    check_beat("empty_beat", 16'h0000, 4'd0, 1'b1, 1'b1, 1'b1);
    tick(); #1;
    check_idle("empty_idle");
  endtask

  task automatic test_backpressure_full();
    logic [WIDTH-1:0] exp_oh;
    int beats = 0;
    data_ready_i = 1'b1;
    send_word(16'hFFFF, 1'b0);
    for (int b = 0; b < WIDTH; b++) begin
      exp_oh = '0;
      exp_oh[b] = 1'b1;
      if (b == 4) begin
        data_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          check_beat("bp_hold", 16'h0010, 4'd4, 1'b0, 1'b0, 1'b0);
          tick();
        end
        data_ready_i = 1'b1;
        #1;
      end
      check_beat("full_beat", exp_oh, IDX_W'(b), (b == WIDTH - 1), 1'b0, (b == WIDTH - 1));
      if (data_val_o && data_ready_i) beats++;
      tick(); #1;
    end
    n_checks++;
    if (beats != 16) begin $display("FAIL full_beat_count got=%0d exp=16", beats); n_fail++; end
    check_idle("full_idle");
  endtask

  task automatic test_back_to_back();
    data_ready_i = 1'b1;
    data_i = 16'h8000; dir_i = 1'b0; data_val_i = 1'b1;
    tick();
    data_i = 16'h0001; dir_i = 1'b1;
    #1;
    check_beat("b2b_first", 16'h8000, 4'd15, 1'b1, 1'b0, 1'b1);
    tick();
    data_val_i = 1'b0;
    #1;
    check_beat("b2b_second", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b1);
    tick(); #1;
    check_idle("b2b_idle");
  endtask

  task automatic test_reset_mid_word();
    data_ready_i = 1'b1;
    send_word(16'hFFFF, 1'b0);
    tick(); tick(); tick();
    #1;
    check_beat("rst_mid_beat4", 16'h0008, 4'd3, 1'b0, 1'b0, 1'b0);
    srst_i = 1'b1;
    #1;
    n_checks++;
    if (data_ready_o !== 1'b0) begin $display("FAIL rst_mid_ready got=%b exp=0", data_ready_o); n_fail++; end
    tick();
    n_checks++;
    if (data_val_o !== 1'b0 || onehot_o !== '0) begin
      $display("FAIL rst_mid_flush got val=%b onehot=%h exp 0/0000", data_val_o, onehot_o); n_fail++;
    end
    srst_i = 1'b0;
    #1;
    check_idle("rst_mid_release");
    tick(); tick(); #1;
    check_idle("rst_mid_no_more");
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_empty();
    test_backpressure_full();
    test_back_to_back();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
